reg_funsel_sequencer: RTL and testbench
=======================================

// Module: reg_funsel_sequencer
// PURPOSE
// - Command-driven initiator for the 16-bit FunSel register interface (FunSel[2:0], I[15:0], E).
// - Takes one high-level command per valid/ready handshake and expands it into the FunSel/E cycle sequence.
// - Sits between control logic and one general-purpose register. Supports repeat inc/dec and split byte loads.
// PARAMETERS
// - CNT_W   8   width of the repeat count for OP_INC_N / OP_DEC_N
// PORTS
// - Clock     in   1      single clock; all state changes on posedge
// - Reset     in   1      synchronous, active-high reset
// - CmdValid  in   1      command present
// - CmdReady  out  1      sequencer accepts a command this cycle
// - CmdOp     in   3      operation code (see BEHAVIOUR)
// - CmdData   in   16     load data
// - CmdCount  in   CNT_W  repeat count for INC_N/DEC_N
// - FunSel    out  3      function select to target register
// - I         out  16     data to target register
// - E         out  1      enable to target register
// - Busy      out  1      command in progress
// - Done      out  1      one-cycle pulse: command complete
// - Err       out  1      one-cycle pulse: reserved opcode rejected
// - Shadow    out  16     model of target register contents (REG_SHADOW_EN only)
// BEHAVIOUR
// - Target FunSel encoding:
//   - 000 dec, 001 inc, 010 load I, 011 clear
//   - 100 load zero-extended I[7:0]
//   - 101 write low byte I[7:0]
//   - 110 write high byte I[15:8]
//   - 111 load sign-extended I[7:0]
// - Opcodes:
//   - 000 LOAD: 1 cycle, FunSel=010, I=CmdData
//   - 001 CLEAR: 1 cycle, FunSel=011
//   - 010 INC_N: CmdCount cycles, FunSel=001
//   - 011 DEC_N: CmdCount cycles, FunSel=000
//   - 100 LOAD_SPLIT: FunSel=101 with I=CmdData for 1 cycle, then FunSel=110 with I=CmdData for 1 cycle
//   - 101 LOAD_ZX: 1 cycle, FunSel=100
//   - 110 LOAD_SX: 1 cycle, FunSel=111
//   - 111 reserved
// - Reset, sampled at posedge (all outputs registered):
//   - FunSel=000, I=0, E=0, Busy=0, Done=0, Err=0, Shadow=0; state=IDLE
//   - Reset mid-command abandons the sequence. No E after the reset edge.
// - States:
//   - IDLE: CmdReady=1. CmdValid&CmdReady latches op, data and count.
//     - Opcode 111: Err=1 for 1 cycle, stay IDLE, no E.
//     - Count==0 for INC_N/DEC_N: go to FIN, no E cycle.
//     - Otherwise go to ISSUE.
//   - ISSUE: E=1, Busy=1.
//     - Repeat ops decrement the internal counter and leave on the last E cycle.
//     - LOAD_SPLIT goes to ISSUE_HI.
//   - ISSUE_HI: E=1, FunSel=110; then FIN.
//   - FIN: E=0, Done=1, Busy=0, CmdReady=1. A new command may be accepted in this cycle; it behaves as accepted in IDLE.
// - Latency: first E cycle is the cycle after acceptance. Done is the cycle after the last E cycle.
// - Total cycles from acceptance to Done:
//   - 1-cycle ops: 2
//   - INC_N/DEC_N: N+1
//   - LOAD_SPLIT: 3
// - CmdReady=0 in ISSUE/ISSUE_HI. CmdData/CmdCount may change after acceptance without effect.
// - When E=0, FunSel and I hold their last values.
// CONFIGURATION
// - REG_SHADOW_EN defined:
//   - Shadow updates on every E cycle using the exact target semantics above.
//   - Inc/dec wrap modulo 2^16.
//   - Writes of 101/110 preserve the other byte.
// - REG_SHADOW_EN undefined: Shadow tied to 16'd0 and no shadow register is built.
// TESTING
// - Reset then LOAD 0x1234 -> E high 1 cycle, FunSel=010, I=0x1234. Done 2 cycles after accept. Shadow=0x1234 (EN).
// - INC_N count=3 from Shadow=0xFFFE -> 3 E cycles, FunSel=001. Done on 4th cycle. Shadow=0x0001 (wrap).
// - LOAD_SPLIT 0xABCD after LOAD 0x0000 -> FunSel 101 then 110, each with E=1. Shadow 0x00CD then 0xABCD.
// - DEC_N count=0 -> no E. Done 1 cycle after accept. Opcode 111 -> Err pulse, no E, no Done.
// - LOAD_SX 0x0080 -> Shadow=0xFF80. LOAD_ZX 0xFF80 -> Shadow=0x0080.
// - Reset during INC_N count=10 after 4 E cycles -> E=0 next cycle, Busy=0, Shadow=0, CmdReady=1.

Source files
------------

// File: rtl/reg_funsel_sequencer.sv
// Command sequencer for a 16-bit FunSel register: expands one handshake command into FunSel/I/E cycles.
// Optional REG_SHADOW_EN builds a shadow copy of the target register; otherwise Shadow reads zero.
module reg_funsel_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [15:0]      CmdData,
  input  logic [CNT_W-1:0] CmdCount,
  output logic [2:0]       FunSel,
  output logic [15:0]      I,
  output logic             E,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [15:0]      Shadow
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_ISSUE_HI = 2'd2,
    ST_FIN      = 2'd3
  } state_e;

  localparam logic [2:0] OP_LOAD       = 3'b000;
  localparam logic [2:0] OP_CLEAR      = 3'b001;
  localparam logic [2:0] OP_INC_N      = 3'b010;
  localparam logic [2:0] OP_DEC_N      = 3'b011;
  localparam logic [2:0] OP_LOAD_SPLIT = 3'b100;
  localparam logic [2:0] OP_LOAD_ZX    = 3'b101;
  localparam logic [2:0] OP_LOAD_SX    = 3'b110;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;
  localparam logic [2:0] FS_ZX    = 3'b100;
  localparam logic [2:0] FS_WR_LO = 3'b101;
  localparam logic [2:0] FS_WR_HI = 3'b110;
  localparam logic [2:0] FS_SX    = 3'b111;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funsel_q, funsel_d;
  logic [15:0]      i_q, i_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             is_repeat_q;
  logic             accept;

  function automatic logic [2:0] op_to_funsel(input logic [2:0] op);
    case (op)
      OP_LOAD:       return FS_LOAD;
      OP_CLEAR:      return FS_CLEAR;
      OP_INC_N:      return FS_INC;
      OP_DEC_N:      return FS_DEC;
      OP_LOAD_SPLIT: return FS_WR_LO;
      OP_LOAD_ZX:    return FS_ZX;
      OP_LOAD_SX:    return FS_SX;
      default:       return FS_LOAD;
    endcase
  endfunction

  assign CmdReady    = (state_q == ST_IDLE) || (state_q == ST_FIN);
  assign accept      = CmdValid && CmdReady;
  assign is_repeat_q = (op_q == OP_INC_N) || (op_q == OP_DEC_N);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    funsel_d = funsel_q;
    i_d      = i_q;
    e_d      = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        // The counter holds the E cycles still owed including the current one.
        if (is_repeat_q && (cnt_q != CNT_W'(1))) begin
          cnt_d  = cnt_q - CNT_W'(1);
          e_d    = 1'b1;
          busy_d = 1'b1;
        end else if (op_q == OP_LOAD_SPLIT) begin
          state_d  = ST_ISSUE_HI;
          funsel_d = FS_WR_HI;
          e_d      = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_ISSUE_HI: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d  = CmdOp;
          cnt_d = CmdCount;
          if (CmdOp == 3'b111) begin
            err_d = 1'b1;
          end else if (((CmdOp == OP_INC_N) || (CmdOp == OP_DEC_N)) && (CmdCount == '0)) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            funsel_d = op_to_funsel(CmdOp);
            i_d      = CmdData;
            e_d      = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      funsel_q <= '0;
      i_q      <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      funsel_q <= funsel_d;
      i_q      <= i_d;
      e_q      <= e_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign FunSel = funsel_q;
  assign I      = i_q;
  assign E      = e_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Err    = err_q;

`ifdef REG_SHADOW_EN
  logic [15:0] shadow_q, shadow_d;

  // Applies the register's own semantics at the edge that ends each E cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (e_q) begin
      case (funsel_q)
        FS_DEC:   shadow_d = shadow_q - 16'd1;
        FS_INC:   shadow_d = shadow_q + 16'd1;
        FS_LOAD:  shadow_d = i_q;
        FS_CLEAR: shadow_d = '0;
        FS_ZX:    shadow_d = {8'h00, i_q[7:0]};
        FS_WR_LO: shadow_d = {shadow_q[15:8], i_q[7:0]};
        FS_WR_HI: shadow_d = {i_q[15:8], shadow_q[7:0]};
        default:  shadow_d = {{8{i_q[7]}}, i_q[7:0]};
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  assign Shadow = shadow_q;
`else
  assign Shadow = '0;
`endif

endmodule

// File: tb/tb_reg_funsel_sequencer.sv
// Directed bench for reg_funsel_sequencer; Shadow expectations follow REG_SHADOW_EN.
module tb_reg_funsel_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [2:0]  CmdOp;
  logic [15:0] CmdData;
  logic [7:0]  CmdCount;
  logic [2:0]  FunSel;
  logic [15:0] I;
  logic        E;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [15:0] Shadow;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef REG_SHADOW_EN
  localparam bit SHADOW_ON = 1'b1;
`else
  localparam bit SHADOW_ON = 1'b0;
`endif

  reg_funsel_sequencer #(.CNT_W(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdData  (CmdData),
    .CmdCount (CmdCount),
    .FunSel   (FunSel),
    .I        (I),
    .E        (E),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .Shadow   (Shadow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sh(input logic [15:0] v);
    return SHADOW_ON ? v : 16'h0000;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents one command for a single edge, then scrambles data/count to show they are not re-sampled.
  task automatic send(input logic [2:0] op, input logic [15:0] data, input logic [7:0] count);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    CmdCount = count;
    step();
    CmdValid = 1'b0;
    CmdData  = ~data;
    CmdCount = 8'hFF;
  endtask

  initial begin
    Reset    = 1'b1;
    CmdValid = 1'b0;
    CmdOp    = 3'b000;
    CmdData  = 16'h0000;
    CmdCount = 8'h00;
    step();
    step();
    Reset = 1'b0;
    chk("rst_funsel", 32'(FunSel), 32'd0);
    chk("rst_i", 32'(I), 32'd0);
    chk("rst_e", 32'(E), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_shadow", 32'(Shadow), 32'd0);
    chk("rst_ready", 32'(CmdReady), 32'd1);

    // LOAD 0x1234
    send(3'b000, 16'h1234, 8'd0);
    chk("ld_e", 32'(E), 32'd1);
    chk("ld_funsel", 32'(FunSel), 32'h2);
    chk("ld_i", 32'(I), 32'h1234);
    chk("ld_busy", 32'(Busy), 32'd1);
    chk("ld_ready", 32'(CmdReady), 32'd0);
    chk("ld_done_early", 32'(Done), 32'd0);
    step();
    chk("ld_done", 32'(Done), 32'd1);
    chk("ld_e_off", 32'(E), 32'd0);
    chk("ld_busy_off", 32'(Busy), 32'd0);
    chk("ld_fin_ready", 32'(CmdReady), 32'd1);
    chk("ld_hold_funsel", 32'(FunSel), 32'h2);
    chk("ld_hold_i", 32'(I), 32'h1234);
    chk("ld_shadow", 32'(Shadow), 32'(sh(16'h1234)));
    step();
    chk("ld_done_pulse", 32'(Done), 32'd0);

    // INC_N x3 from 0xFFFE wraps to 0x0001
    send(3'b000, 16'hFFFE, 8'd0);
    step();
    step();
    send(3'b010, 16'h5555, 8'd3);
    chk("inc_e1", 32'(E), 32'd1);
    chk("inc_funsel", 32'(FunSel), 32'h1);
    step();
    chk("inc_e2", 32'(E), 32'd1);
    step();
    chk("inc_e3", 32'(E), 32'd1);
    chk("inc_done_early", 32'(Done), 32'd0);
    step();
    chk("inc_e_off", 32'(E), 32'd0);
    chk("inc_done", 32'(Done), 32'd1);
    chk("inc_shadow", 32'(Shadow), 32'(sh(16'h0001)));

    // Back-to-back acceptance from FIN: LOAD 0, then LOAD_SPLIT 0xABCD
    chk("fin_ready", 32'(CmdReady), 32'd1);
    send(3'b000, 16'h0000, 8'd0);
    chk("b2b_e", 32'(E), 32'd1);
    chk("b2b_i", 32'(I), 32'h0000);
    step();
    chk("b2b_done", 32'(Done), 32'd1);
    send(3'b100, 16'hABCD, 8'd0);
    chk("spl_lo_e", 32'(E), 32'd1);
    chk("spl_lo_funsel", 32'(FunSel), 32'h5);
    chk("spl_lo_i", 32'(I), 32'hABCD);
    step();
    chk("spl_hi_e", 32'(E), 32'd1);
    chk("spl_hi_funsel", 32'(FunSel), 32'h6);
    chk("spl_hi_ready", 32'(CmdReady), 32'd0);
    chk("spl_sh_lo", 32'(Shadow), 32'(sh(16'h00CD)));
    step();
    chk("spl_done", 32'(Done), 32'd1);
    chk("spl_e_off", 32'(E), 32'd0);
    chk("spl_sh_hi", 32'(Shadow), 32'(sh(16'hABCD)));
    step();

    // DEC_N with count 0: no E, Done next cycle
    send(3'b011, 16'h0000, 8'd0);
    chk("dec0_e", 32'(E), 32'd0);
    chk("dec0_done", 32'(Done), 32'd1);
    chk("dec0_busy", 32'(Busy), 32'd0);
    step();
    chk("dec0_done_pulse", 32'(Done), 32'd0);
    chk("dec0_shadow", 32'(Shadow), 32'(sh(16'hABCD)));

    // Reserved opcode
    send(3'b111, 16'h1111, 8'd4);
    chk("rsv_err", 32'(Err), 32'd1);
    chk("rsv_e", 32'(E), 32'd0);
    chk("rsv_done", 32'(Done), 32'd0);
    chk("rsv_ready", 32'(CmdReady), 32'd1);
    step();
    chk("rsv_err_pulse", 32'(Err), 32'd0);
    chk("rsv_e_after", 32'(E), 32'd0);

    // Sign- and zero-extended byte loads
    send(3'b110, 16'h0080, 8'd0);
    chk("sx_funsel", 32'(FunSel), 32'h7);
    chk("sx_e", 32'(E), 32'd1);
    step();
    chk("sx_shadow", 32'(Shadow), 32'(sh(16'hFF80)));
    step();
    send(3'b101, 16'hFF80, 8'd0);
    chk("zx_funsel", 32'(FunSel), 32'h4);
    chk("zx_i", 32'(I), 32'hFF80);
    step();
    chk("zx_shadow", 32'(Shadow), 32'(sh(16'h0080)));
    step();

    // DEC_N x2: 0x0080 -> 0x007E
    send(3'b011, 16'h0000, 8'd2);
    chk("dec_funsel", 32'(FunSel), 32'h0);
    chk("dec_e1", 32'(E), 32'd1);
    step();
    chk("dec_e2", 32'(E), 32'd1);
    step();
    chk("dec_done", 32'(Done), 32'd1);
    chk("dec_shadow", 32'(Shadow), 32'(sh(16'h007E)));
    step();

    // Reset during INC_N x10 after four E cycles
    send(3'b010, 16'h0000, 8'd10);
    step();
    step();
    step();
    chk("rst_mid_e4", 32'(E), 32'd1);
    chk("rst_mid_sh3", 32'(Shadow), 32'(sh(16'h0081)));
    Reset = 1'b1;
    step();
    chk("rst_mid_e", 32'(E), 32'd0);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_shadow", 32'(Shadow), 32'd0);
    chk("rst_mid_ready", 32'(CmdReady), 32'd1);
    chk("rst_mid_funsel", 32'(FunSel), 32'd0);
    Reset = 1'b0;
    step();
    chk("rst_mid_e_after", 32'(E), 32'd0);
    chk("rst_mid_done_after", 32'(Done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
